// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
// Read-side consumer for the synchronous FIFO. Narrow FIFO words are
// acknowledged one per cycle and packed little-endian into a wide word
// (lane 0 = first word). The wide word is offered downstream with a
// registered oready and held until oack. A partially filled word is flushed
// after TIMEOUT consecutive idle cycles so a slow trickle of data is never
// stranded in the packer.
//
// Handshake contract (both sides):
//   upstream   : rready=1 means rdata holds the FIFO head word. rack=1 in a
//                cycle consumes that word at the next rising edge. rack is
//                combinational and is never high while rready=0 or rst=1.
//   downstream : oready=1 means odata/ocount are valid. They stay stable
//                until a rising edge with oready=1 and oack=1 transfers the
//                word. oack while oready=0 has no effect.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rready,
  input  logic [DATA_WIDTH-1:0]         rdata,
  output logic                          rack,
  output logic                          oready,
  output logic [DATA_WIDTH*RATIO-1:0]   odata,
  output logic [$clog2(RATIO+1)-1:0]    ocount,
  input  logic                          oack
);

  // Widths are clamped to at least one bit so degenerate parameter values
  // (RATIO=1, TIMEOUT=0) still elaborate cleanly.
  localparam int CW = $clog2(RATIO + 1);
  localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [IW-1:0] IDX_LAST   = IW'(RATIO - 1);
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] COUNT_FULL = CW'(RATIO);
  localparam bit            FLUSH_EN   = (TIMEOUT > 0);

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_t;

  state_t                  state_q;
  logic [IW-1:0]           idx_q;
  logic [TW-1:0]           timer_q;
  logic [DATA_WIDTH-1:0]   lane_q [RATIO];
  logic                    oready_q;
  logic [CW-1:0]           ocount_q;

  // Per-cycle decisions taken from the current state.
  logic                    accept;
  logic                    last_lane;
  logic                    partial;
  logic                    timer_expire;
  logic                    flush;

  // Consume the head word only while collecting and out of reset.
  assign rack = ~rst & rready & (state_q == COLLECT);

  // Decode acceptance, full-word completion and idle-timeout flush; an
  // arriving word always wins over an expiring timer.
  always_comb begin
    accept       = rack;
    last_lane    = (idx_q == IDX_LAST);
    partial      = (idx_q != '0);
    timer_expire = (timer_q == TIMER_LAST);
    flush        = FLUSH_EN && (state_q == COLLECT) && !accept && partial && timer_expire;
  end

  // Packer FSM: collects lanes, raises oready on a full word or a timeout
  // flush, then waits for the downstream acknowledge and clears the lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      idx_q    <= '0;
      timer_q  <= '0;
      oready_q <= 1'b0;
      ocount_q <= '0;
      for (int i = 0; i < RATIO; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            lane_q[idx_q] <= rdata;
            timer_q       <= '0;
            if (last_lane) begin
              state_q  <= OUTPUT;
              ocount_q <= COUNT_FULL;
              oready_q <= 1'b1;
              idx_q    <= '0;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end else if (flush) begin
            // Lanes at and above idx_q were cleared when the previous word
            // left, so the unused upper lanes already read as zero.
            state_q  <= OUTPUT;
            ocount_q <= CW'(idx_q);
            oready_q <= 1'b1;
            idx_q    <= '0;
            timer_q  <= '0;
          end else if (FLUSH_EN && partial) begin
            timer_q <= timer_q + TW'(1);
          end else begin
            // Empty packer (or flush disabled): nothing to time out.
            timer_q <= '0;
          end
        end

        OUTPUT: begin
          if (oack) begin
            state_q  <= COLLECT;
            oready_q <= 1'b0;
            for (int i = 0; i < RATIO; i++) begin
              lane_q[i] <= '0;
            end
          end
        end

        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

  // The wide word is read straight from the lane registers.
  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    assign odata[g*DATA_WIDTH +: DATA_WIDTH] = lane_q[g];
  end

  assign oready = oready_q;
  assign ocount = ocount_q;

endmodule
